// File: rtl/conv3x3_pkg.sv
// Shared types and helpers for the streaming 3x3 filter engine.
package conv3x3_pkg;

    typedef enum logic [1:0] {
        MODE_PASS  = 2'd0,
        MODE_SOBX  = 2'd1,
        MODE_SOBY  = 2'd2,
        MODE_GAUSS = 2'd3
    } mode_e;

    localparam int LATENCY = 3;

    // Clamp an unsigned magnitude to the largest value representable in 'width' bits.
    function automatic logic [31:0] saturate(input logic [31:0] val, input int unsigned width);
        logic [31:0] max_v;
        max_v = (32'd1 << width) - 32'd1;
        return (val > max_v) ? max_v : val;
    endfunction

endpackage

// File: rtl/conv3x3_stream_if.sv
// Pixel stream into the filter and filtered stream out, grouped for port connection.
interface conv3x3_stream_if #(
    parameter int DATA_W  = 12,
    parameter int COORD_W = 16
);
    logic [DATA_W-1:0]  iDATA;
    logic               iDVAL;
    logic [COORD_W-1:0] iX_Cont;
    logic [COORD_W-1:0] iY_Cont;
    logic [1:0]         iMode;
    logic [DATA_W-1:0]  oDATA;
    logic               oDVAL;
    logic               oOVF;

    modport master (
        output iDATA, iDVAL, iX_Cont, iY_Cont, iMode,
        input  oDATA, oDVAL, oOVF
    );

    modport slave (
        input  iDATA, iDVAL, iX_Cont, iY_Cont, iMode,
        output oDATA, oDVAL, oOVF
    );
endinterface

// File: rtl/line_buffer_2row.sv
// Two stacked row buffers: read-before-write, the older row shifts down as a new pixel lands.
module line_buffer_2row #(
    parameter int DATA_W   = 12,
    parameter int MAX_COLS = 1280,
    parameter int ADDR_W   = 11
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] buf0_o,
    output logic [DATA_W-1:0] buf1_o
);

    logic [DATA_W-1:0] buf0_mem [MAX_COLS];
    logic [DATA_W-1:0] buf1_mem [MAX_COLS];
    logic [DATA_W-1:0] buf0_q;
    logic [DATA_W-1:0] buf1_q;

    // NOTE: the arrays are deliberately left out of reset; stale rows are masked by the border flag.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            buf1_mem[addr_i] <= buf0_mem[addr_i];
            buf0_mem[addr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            buf0_q <= '0;
            buf1_q <= '0;
        end else if (en_i) begin
            buf0_q <= buf0_mem[addr_i];
            buf1_q <= buf1_mem[addr_i];
        end
    end

    assign buf0_o = buf0_q;
    assign buf1_o = buf1_q;

endmodule

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 filter: line buffers build the window, the kernel is chosen once per frame.
module conv3x3_stream
    import conv3x3_pkg::*;
#(
    parameter int DATA_W   = 12,
    parameter int MAX_COLS = 1280,
    parameter int COORD_W  = 16,
    parameter int SHIFT    = 2
) (
    input  logic            iCLK,
    input  logic            iRST,
    conv3x3_stream_if.slave bus
);

    localparam int ADDR_W = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1;
    localparam int GW     = DATA_W + 4;

    logic                 at_origin, accept, col_ovf, border;
    mode_e                pix_mode;
    logic [DATA_W-1:0]    rd_buf0, rd_buf1;

    logic                 armed_q, ovf_q;
    mode_e                mode_q, s1_mode_q, s2_mode_q;
    logic [LATENCY-1:0]   dval_q;
    logic [DATA_W-1:0]    s1_data_q;
    logic                 s1_zero_q, s2_zero_q;
    logic [DATA_W-1:0]    win_q [3][3];
    logic [DATA_W-1:0]    data_q, data_d;

    logic signed [GW-1:0] gx, gy, g_sel;
    logic [GW-1:0]        g_abs, gauss_sum;

    assign at_origin = (bus.iX_Cont == '0) && (bus.iY_Cont == '0);
    // Nothing enters the pipeline until a frame has been opened by an origin pixel.
    assign accept    = bus.iDVAL && (armed_q || at_origin);
    assign col_ovf   = bus.iX_Cont >= COORD_W'(MAX_COLS);
    assign border    = (bus.iY_Cont <= COORD_W'(1)) || (bus.iX_Cont <= COORD_W'(1)) || col_ovf;
    assign pix_mode  = at_origin ? mode_e'(bus.iMode) : mode_q;

    line_buffer_2row #(
        .DATA_W   (DATA_W),
        .MAX_COLS (MAX_COLS),
        .ADDR_W   (ADDR_W)
    ) u_line_buffer (
        .clk_i   (iCLK),
        .rst_i   (iRST),
        .en_i    (accept),
        .we_i    (accept && !col_ovf),
        .addr_i  (ADDR_W'(bus.iX_Cont)),
        .wdata_i (bus.iDATA),
        .buf0_o  (rd_buf0),
        .buf1_o  (rd_buf1)
    );

    function automatic logic signed [GW-1:0] sx(input logic [DATA_W-1:0] p);
        return $signed({4'b0000, p});
    endfunction

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        gx = (sx(win_q[0][2]) + (sx(win_q[1][2]) <<< 1) + sx(win_q[2][2]))
           - (sx(win_q[0][0]) + (sx(win_q[1][0]) <<< 1) + sx(win_q[2][0]));
        gy = (sx(win_q[2][0]) + (sx(win_q[2][1]) <<< 1) + sx(win_q[2][2]))
           - (sx(win_q[0][0]) + (sx(win_q[0][1]) <<< 1) + sx(win_q[0][2]));
        g_sel = (s2_mode_q == MODE_SOBY) ? gy : gx;
        g_abs = g_sel[GW-1] ? -g_sel : g_sel;
        gauss_sum = GW'(win_q[0][0]) + (GW'(win_q[0][1]) << 1) + GW'(win_q[0][2])
                  + (GW'(win_q[1][0]) << 1) + (GW'(win_q[1][1]) << 2) + (GW'(win_q[1][2]) << 1)
                  + GW'(win_q[2][0]) + (GW'(win_q[2][1]) << 1) + GW'(win_q[2][2]);
        data_d = '0;
        case (s2_mode_q)
            MODE_PASS:            data_d = win_q[1][1];
            MODE_SOBX, MODE_SOBY: data_d = DATA_W'(saturate(32'(g_abs >> SHIFT), DATA_W));
            MODE_GAUSS:           data_d = DATA_W'(gauss_sum >> 4);
            default:              data_d = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so stage order is irrelevant.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            armed_q   <= 1'b0;
            ovf_q     <= 1'b0;
            mode_q    <= MODE_PASS;
            s1_mode_q <= MODE_PASS;
            s2_mode_q <= MODE_PASS;
            dval_q    <= '0;
            s1_data_q <= '0;
            s1_zero_q <= 1'b0;
            s2_zero_q <= 1'b0;
            data_q    <= '0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else begin
            dval_q <= {dval_q[LATENCY-2:0], accept};
            if (accept) begin
                s1_data_q <= bus.iDATA;
                s1_zero_q <= border;
                s1_mode_q <= pix_mode;
                if (at_origin) begin
                    armed_q <= 1'b1;
                    mode_q  <= pix_mode;
                end
                if (col_ovf) ovf_q <= 1'b1;
            end
            if (dval_q[0]) begin
                for (int r = 0; r < 3; r++) begin
                    win_q[r][0] <= win_q[r][1];
                    win_q[r][1] <= win_q[r][2];
                end
                win_q[2][2] <= s1_data_q;
                win_q[1][2] <= rd_buf0;
                win_q[0][2] <= rd_buf1;
                s2_zero_q   <= s1_zero_q;
                s2_mode_q   <= s1_mode_q;
            end
            if (dval_q[1]) data_q <= s2_zero_q ? '0 : data_d;
        end
    end

    assign bus.oDATA = data_q;
    assign bus.oDVAL = dval_q[LATENCY-1];
    assign bus.oOVF  = ovf_q;

endmodule
